// File: rtl/systolic_seq.sv
// Tile sequencer for an N x N weight-stationary systolic array: loads weight rows,
// fires the skewed switch wave, streams skewed input vectors, then drains.
// Optional stall counter port enabled by `define SYSTOLIC_SEQ_STALL_CNT_EN.
module systolic_seq #(
  parameter int N     = 2,
  parameter int VEC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [VEC_W-1:0]   num_vecs,
  input  logic               w_valid,
  output logic               w_ready,
  input  logic [N*16-1:0]    w_data,
  input  logic               x_valid,
  output logic               x_ready,
  input  logic [N*16-1:0]    x_data,
  output logic [N*16-1:0]    arr_weight,
  output logic [N-1:0]       arr_accept,
  output logic [N-1:0]       arr_switch,
  output logic [N*16-1:0]    arr_input,
  output logic [N-1:0]       arr_valid,
  output logic               busy,
  output logic               done
`ifdef SYSTOLIC_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int RW = $clog2(N + 1);
  localparam int DW = (N > 1) ? $clog2(2 * N - 1) : 1;
  localparam logic [RW-1:0] ROW_LAST   = RW'(N);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(2 * N - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SWITCH,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [RW-1:0]      r_row_cnt;
  logic [VEC_W-1:0]   r_vec_cnt;
  logic [VEC_W-1:0]   r_num;
  logic [DW-1:0]      r_drain_cnt;
  logic [N-1:0]       r_sw_p0;
  logic               w_w_hs;
  logic               w_x_hs;
  logic               w_start_acc;

  // Ready drops in the cycle the counter hits its target; that cycle is the transition cycle.
  assign w_ready     = (r_state == S_LOAD)   && (r_row_cnt != ROW_LAST);
  assign x_ready     = (r_state == S_STREAM) && (r_vec_cnt != r_num);
  assign w_w_hs      = w_valid & w_ready;
  assign w_x_hs      = x_valid & x_ready;
  assign w_start_acc = (r_state == S_IDLE) && start;
  assign busy        = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_LOAD;
      S_LOAD:   if (r_row_cnt == ROW_LAST) w_state_nxt = S_SWITCH;
      S_SWITCH: w_state_nxt = (r_num == '0) ? S_DRAIN : S_STREAM;
      S_STREAM: if (r_vec_cnt == r_num) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (r_drain_cnt == DRAIN_LAST) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_row_cnt   <= '0;
      r_vec_cnt   <= '0;
      r_num       <= '0;
      r_drain_cnt <= '0;
      done        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_acc) begin
        r_num     <= num_vecs;
        r_row_cnt <= '0;
      end else if (w_w_hs) begin
        r_row_cnt <= r_row_cnt + 1'b1;
      end
      if (r_state == S_SWITCH)
        r_vec_cnt <= '0;
      else if (w_x_hs)
        r_vec_cnt <= r_vec_cnt + 1'b1;
      r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 1'b1 : '0;
      done        <= (r_state == S_DRAIN) && (r_drain_cnt == DRAIN_LAST);
    end
  end

  // Stage p0: weight row register and switch skew line (row r taps stage r)
  always_ff @(posedge clk) begin
    if (rst) begin
      arr_weight <= '0;
      arr_accept <= '0;
      r_sw_p0    <= '0;
    end else begin
      arr_weight <= w_w_hs ? w_data : '0;
      arr_accept <= {N{w_w_hs}};
      r_sw_p0[0] <= (r_state == S_SWITCH);
      for (int i = 1; i < N; i++)
        r_sw_p0[i] <= r_sw_p0[i-1];
    end
  end

  assign arr_switch = r_sw_p0;

  // Stage p0..pR: per-row input skew line, row r is r+1 registers deep
  for (genvar gr = 0; gr < N; gr++) begin : g_row
    logic [gr:0][15:0] r_in_p;
    logic [gr:0]       r_vld_p;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_in_p  <= '0;
        r_vld_p <= '0;
      end else begin
        r_in_p[0]  <= w_x_hs ? x_data[16*gr +: 16] : 16'h0000;
        r_vld_p[0] <= w_x_hs;
        for (int k = 1; k <= gr; k++) begin
          r_in_p[k]  <= r_in_p[k-1];
          r_vld_p[k] <= r_vld_p[k-1];
        end
      end
    end

    assign arr_input[16*gr +: 16] = r_in_p[gr];
    assign arr_valid[gr]          = r_vld_p[gr];
  end

`ifdef SYSTOLIC_SEQ_STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = (w_ready && !w_valid) || (x_ready && !x_valid);

  always_ff @(posedge clk) begin
    if (rst || w_start_acc)
      r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_systolic_seq.sv
// Directed bench for systolic_seq (N=2): nominal tile, weight gap, input bubble,
// zero-vector tile, mid-stream reset and start held high across tiles.
module tb_systolic_seq;

  localparam int N     = 2;
  localparam int VEC_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [VEC_W-1:0]  num_vecs;
  logic              w_valid;
  logic              w_ready;
  logic [N*16-1:0]   w_data;
  logic              x_valid;
  logic              x_ready;
  logic [N*16-1:0]   x_data;
  logic [N*16-1:0]   arr_weight;
  logic [N-1:0]      arr_accept;
  logic [N-1:0]      arr_switch;
  logic [N*16-1:0]   arr_input;
  logic [N-1:0]      arr_valid;
  logic              busy;
  logic              done;
`ifdef SYSTOLIC_SEQ_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  systolic_seq #(.N(N), .VEC_W(VEC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_vecs   (num_vecs),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_data     (w_data),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .x_data     (x_data),
    .arr_weight (arr_weight),
    .arr_accept (arr_accept),
    .arr_switch (arr_switch),
    .arr_input  (arr_input),
    .arr_valid  (arr_valid),
    .busy       (busy),
    .done       (done)
`ifdef SYSTOLIC_SEQ_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Nominal tile, num_vecs=3, start at cycle 0; index = cycle number.
  logic [1:0]  e_acc  [0:12] = '{0,0,3,3,0,0,0,0,0,0,0,0,0};
  logic [31:0] e_wgt  [0:12] = '{0,0,32'h0002_0001,32'h0004_0003,0,0,0,0,0,0,0,0,0};
  logic [1:0]  e_sw   [0:12] = '{0,0,0,0,0,1,2,0,0,0,0,0,0};
  logic [1:0]  e_vld  [0:12] = '{0,0,0,0,0,0,1,3,3,2,0,0,0};
  logic [31:0] e_inp  [0:12] = '{0,0,0,0,0,0,32'h0000_00A1,32'h00B1_00A2,
                                 32'h00B2_00A3,32'h00B3_0000,0,0,0};
  logic        e_done [0:12] = '{0,0,0,0,0,0,0,0,0,0,0,0,1};
  logic        e_busy [0:12] = '{0,1,1,1,1,1,1,1,1,1,1,1,0};
  logic        e_wrdy [0:12] = '{0,1,1,0,0,0,0,0,0,0,0,0,0};
  logic        e_xrdy [0:12] = '{0,0,0,0,0,1,1,1,0,0,0,0,0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; num_vecs = '0;
    w_valid = 1'b0; w_data = '0; x_valid = 1'b0; x_data = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_busy",   busy, 0);
    chk("rst_done",   done, 0);
    chk("rst_wrdy",   w_ready, 0);
    chk("rst_xrdy",   x_ready, 0);
    chk("rst_outs",   {arr_weight, arr_accept, arr_switch, arr_input, arr_valid}, 0);

    // Nominal tile; start is held high throughout and must be ignored while busy.
    start = 1'b1; num_vecs = 8'd3; w_valid = 1'b1; x_valid = 1'b1;
    w_data = 32'hFFFF_FFFF; x_data = 32'hDEAD_BEEF;
    for (int c = 1; c <= 12; c++) begin
      step();
      chk($sformatf("t1_acc_c%0d", c),  arr_accept, e_acc[c]);
      chk($sformatf("t1_wgt_c%0d", c),  arr_weight, e_wgt[c]);
      chk($sformatf("t1_sw_c%0d", c),   arr_switch, e_sw[c]);
      chk($sformatf("t1_vld_c%0d", c),  arr_valid,  e_vld[c]);
      chk($sformatf("t1_inp_c%0d", c),  arr_input,  e_inp[c]);
      chk($sformatf("t1_done_c%0d", c), done,       e_done[c]);
      chk($sformatf("t1_busy_c%0d", c), busy,       e_busy[c]);
      chk($sformatf("t1_wrdy_c%0d", c), w_ready,    e_wrdy[c]);
      chk($sformatf("t1_xrdy_c%0d", c), x_ready,    e_xrdy[c]);
      num_vecs = 8'hFF;
      w_data = (c == 1) ? 32'h0002_0001 : (c == 2) ? 32'h0004_0003 : 32'hFFFF_FFFF;
      x_data = (c == 5) ? 32'h00B1_00A1 : (c == 6) ? 32'h00B2_00A2 :
               (c == 7) ? 32'h00B3_00A3 : 32'hDEAD_BEEF;
`ifdef SYSTOLIC_SEQ_STALL_CNT_EN
      if (c == 12) chk("t1_stall", stall_cnt, 0);
`endif
    end

    // Tile 2 accepted in the done cycle: weight gap of 2 cycles, input bubble.
    num_vecs = 8'd2;
    step();                                            // t=1 LOAD
    chk("t2_accepted_busy", busy, 1);
    chk("t2_wrdy1", w_ready, 1);
    start = 1'b0; w_data = 32'h1111_2222;
    step();                                            // t=2
    chk("t2_acc_row0", arr_accept, 2'b11);
    chk("t2_wgt_row0", arr_weight, 32'h1111_2222);
    w_valid = 1'b0; w_data = 32'h5555_5555;
    step();                                            // t=3 gap
    chk("t2_gap_acc", arr_accept, 0);
    chk("t2_gap_wgt", arr_weight, 0);
    chk("t2_gap_wrdy", w_ready, 1);
    step();                                            // t=4 gap
    chk("t2_gap2_acc", arr_accept, 0);
    chk("t2_gap2_wgt", arr_weight, 0);
    chk("t2_gap2_wrdy", w_ready, 1);
    w_valid = 1'b1; w_data = 32'h3333_4444;
    step();                                            // t=5 transition
    chk("t2_acc_row1", arr_accept, 2'b11);
    chk("t2_wgt_row1", arr_weight, 32'h3333_4444);
    chk("t2_wrdy_last", w_ready, 0);
`ifdef SYSTOLIC_SEQ_STALL_CNT_EN
    chk("t2_stall_load", stall_cnt, 2);
`endif
    step();                                            // t=6 SWITCH
    chk("t2_sw_none", arr_switch, 0);
    x_data = 32'h00C1_00D1;
    step();                                            // t=7
    chk("t2_sw0", arr_switch, 2'b01);
    chk("t2_xrdy", x_ready, 1);
    step();                                            // t=8
    chk("t2_sw1", arr_switch, 2'b10);
    chk("t2_vld_v1r0", arr_valid, 2'b01);
    chk("t2_inp_v1r0", arr_input, 32'h0000_00D1);
    x_valid = 1'b0; x_data = 32'hBAD0_BAD0;
    step();                                            // t=9 bubble on row 0
    chk("t2_vld_bub_r0", arr_valid, 2'b10);
    chk("t2_inp_bub_r0", arr_input, 32'h00C1_0000);
`ifdef SYSTOLIC_SEQ_STALL_CNT_EN
    chk("t2_stall_bubble", stall_cnt, 3);
`endif
    x_valid = 1'b1; x_data = 32'h00C2_00D2;
    step();                                            // t=10 bubble on row 1
    chk("t2_vld_bub_r1", arr_valid, 2'b01);
    chk("t2_inp_bub_r1", arr_input, 32'h0000_00D2);
    chk("t2_xrdy_drop", x_ready, 0);
    step();                                            // t=11
    chk("t2_vld_v2r1", arr_valid, 2'b10);
    chk("t2_inp_v2r1", arr_input, 32'h00C2_0000);
    step(); step();                                    // t=13
    chk("t2_done_early", done, 0);
    step();                                            // t=14
    chk("t2_done", done, 1);
    chk("t2_busy_done", busy, 0);
`ifdef SYSTOLIC_SEQ_STALL_CNT_EN
    chk("t2_stall_hold", stall_cnt, 3);
`endif

    // Tile 3: num_vecs=0 goes SWITCH -> DRAIN with no valid inputs.
    start = 1'b1; num_vecs = 8'd0; w_data = 32'hFFFF_FFFF;
    for (int u = 1; u <= 8; u++) begin
      step();
      start = 1'b0;
      chk($sformatf("t3_vld_u%0d", u),  arr_valid, 0);
      chk($sformatf("t3_xrdy_u%0d", u), x_ready, 0);
      chk($sformatf("t3_done_u%0d", u), done, (u == 8));
      if (u == 5) chk("t3_sw0", arr_switch, 2'b01);
      if (u == 6) chk("t3_sw1", arr_switch, 2'b10);
    end

    // Tile 4: reset pulsed mid-stream.
    start = 1'b1; num_vecs = 8'd3; x_data = 32'h00B1_00A1;
    for (int v = 1; v <= 6; v++) begin
      step();
      start = 1'b0;
    end
    chk("t4_vld_before_rst", arr_valid, 2'b01);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_rst_outs", {arr_weight, arr_accept, arr_switch, arr_input, arr_valid}, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_done", done, 0);
    chk("t4_rst_rdy", {w_ready, x_ready}, 0);
    for (int v = 8; v <= 12; v++) begin
      step();
      chk($sformatf("t4_no_done_v%0d", v), done, 0);
      chk($sformatf("t4_idle_v%0d", v),    busy, 0);
    end

    // Tile 5: clean single-vector tile after the abandoned one.
    start = 1'b1; num_vecs = 8'd1; x_data = 32'h0077_0066;
    for (int z = 1; z <= 10; z++) begin
      step();
      start = 1'b0;
      chk($sformatf("t5_done_z%0d", z), done, (z == 10));
      if (z == 6) begin
        chk("t5_vld_r0", arr_valid, 2'b01);
        chk("t5_inp_r0", arr_input, 32'h0000_0066);
      end
      if (z == 7) begin
        chk("t5_vld_r1", arr_valid, 2'b10);
        chk("t5_inp_r1", arr_input, 32'h0077_0000);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
